cat_calc_sequencer: RTL

Controller between the APB register/pixel memory and the neuron datapath. In write mode it passes APB write addresses through to the pixel and weight memories. On a start request it takes ownership of the shared memory address, streams Num_Pixels read addresses, and aligns the multiply-accumulate enable with memory read latency. It then pulses get_result and holds done until software releases start.

---
 rtl/cat_calc_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cat_calc_sequencer.sv
// cat_calc_sequencer
//   Sits between the APB register/pixel memory and the neuron datapath.
//   In IDLE the APB write address and strobe pass straight through to the
//   pixel/weight memories. A rising edge on start takes over the shared
//   memory address, streams Num_Pixels read addresses, delays the
//   multiply-accumulate enable by the memory read latency, pulses
//   get_result and holds done until software drops start.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   start           level from control_reg[0]
//   apb_wr_en       APB write strobe
//   apb_addr        APB write address
//   mem_address     shared pixel/weight memory address
//   mem_en_write    pixel memory write enable (IDLE only)
//   mem_en_read     pixel/weight memory read enable
//   mac_clear       accumulator clear
//   mac_enable      accumulate current x/w pair
//   get_result      one-cycle pulse, accumulator final
//   busy            CLEAR, READ, DRAIN or RESULT
//   done            DONE state
//   start_ack       one-cycle pulse on an accepted start
//   write_dropped   one-cycle pulse, APB write lost while not IDLE
//
// state  | meaning
// IDLE   | APB owns the memory address, waiting for a start edge
// CLEAR  | clear the accumulator, reset read address
// READ   | issue read addresses 0..Num_Pixels-1
// DRAIN  | wait Mem_Latency cycles for the last data to be accumulated
// RESULT | accumulator final, pulse get_result
// DONE   | hold done until start is released
module cat_calc_sequencer #(
  parameter int Amba_Addr_Depth = 12,
  parameter int Num_Pixels      = 4096,
  parameter int Mem_Latency     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       apb_wr_en,
  input  logic [Amba_Addr_Depth-1:0] apb_addr,
  output logic [Amba_Addr_Depth-1:0] mem_address,
  output logic                       mem_en_write,
  output logic                       mem_en_read,
  output logic                       mac_clear,
  output logic                       mac_enable,
  output logic                       get_result,
  output logic                       busy,
  output logic                       done,
  output logic                       start_ack,
  output logic                       write_dropped
);

  localparam logic [Amba_Addr_Depth-1:0] LAST_ADDR  = Amba_Addr_Depth'(Num_Pixels - 1);
  localparam logic [Amba_Addr_Depth-1:0] ADDR_ONE   = Amba_Addr_Depth'(1);
  localparam logic [1:0]                 DRAIN_LOAD = 2'(Mem_Latency - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                       state, state_nxt;
  logic                         start_q;
  logic                         armed;
  logic                         abort_q;
  logic [Amba_Addr_Depth-1:0]   rd_addr;
  logic [Mem_Latency-1:0]       valid_pipe;
  logic [1:0]                   drain_cnt;
  logic                         accept;
  logic                         abort;

  assign mac_enable = valid_pipe[Mem_Latency-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      armed      <= 1'b0;
      abort_q    <= 1'b0;
      start_ack  <= 1'b0;
      rd_addr    <= '0;
      valid_pipe <= '0;
      drain_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      start_q   <= start;
      // A start level still high across reset must go low before it can
      // trigger again, so acceptance waits until start has been seen low.
      armed     <= armed | ~start;
      abort_q   <= abort;
      start_ack <= accept;

      if (state == CLEAR || abort)
        rd_addr <= '0;
      else if (state == READ)
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_ONE;

      if (abort) begin
        valid_pipe <= '0;
      end else begin
        valid_pipe[0] <= mem_en_read;
        for (int i = 1; i < Mem_Latency; i++)
          valid_pipe[i] <= valid_pipe[i-1];
      end

      if (state != DRAIN && state_nxt == DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    abort         = 1'b0;
    mem_en_read   = 1'b0;
    mac_clear     = abort_q;
    get_result    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    mem_en_write  = apb_wr_en & (state == IDLE);
    write_dropped = apb_wr_en & (state != IDLE);
    mem_address   = (state == IDLE) ? apb_addr : rd_addr;

    case (state)
      IDLE: begin
        if (start && !start_q && armed) begin
          accept    = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        mac_clear = 1'b1;
        if (!start) abort = 1'b1;
        else        state_nxt = READ;
      end
      READ: begin
        busy        = 1'b1;
        mem_en_read = 1'b1;
        if (!start)                    abort = 1'b1;
        else if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!start)                 abort = 1'b1;
        else if (drain_cnt == 2'd0) state_nxt = RESULT;
      end
      RESULT: begin
        busy       = 1'b1;
        get_result = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) state_nxt = IDLE;
  end

endmodule
